ff_share_arbiter: RTL and testbench
===================================

// Module: ff_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one DATA_W-bit register (the ff datapath) among N_REQ requesters.
//  Grants one requester at a time, loads the winner's data into the shared register each granted cycle,
//  and enforces a hold limit so no requester starves the others. Sits between requester TBs/blocks and ff.
// PARAMETERS
//  N_REQ     4   number of requesters (>=2)
//  DATA_W    8   width of shared register and each requester's data
//  MAX_HOLD  4   max consecutive captures per grant before forced release (>=1)
// PORTS
//  clk      in   1              clock; all state updates on rising edge
//  rst      in   1              synchronous, active-high reset
//  req      in   N_REQ          per-requester request, level
//  d        in   N_REQ*DATA_W   packed [N_REQ-1:0][DATA_W-1:0] requester data
//  gnt      out  N_REQ          one-hot grant, registered; all-zero when idle
//  owner    out  $clog2(N_REQ)  index of current grantee; valid only while busy
//  busy     out  1              1 when any gnt bit set (state OWN)
//  q        out  DATA_W         shared register contents
//  q_valid  out  1              1 in cycle after a capture edge, else 0
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides everything, incl. mid-grant): gnt=0, owner=0, busy=0, q=0, q_valid=0,
//   state=IDLE, ptr=0, hold_cnt=0. Takes effect at that edge; req ignored while rst=1.
//  Round-robin pick: first set bit of req scanning ptr, ptr+1, ... wrapping mod N_REQ.
//  IDLE: if |req -> gnt<=onehot(pick), owner<=pick, hold_cnt<=0, state<=OWN; q_valid<=0. Latency req->gnt = 1 clk.
//  OWN (owner i), at each edge:
//   req[i]=1: capture q<=d[i], q_valid<=1, hold_cnt<=hold_cnt+1; if hold_cnt+1==MAX_HOLD -> release.
//   req[i]=0: no capture, q_valid<=0, release (voluntary).
//  Release: ptr<=(i+1) mod N_REQ; pick using new ptr over current req (includes i if still requesting).
//   pick exists -> gnt<=onehot(pick), hold_cnt<=0, stay OWN (no idle gap, even if pick==i).
//   none -> gnt<=0, state<=IDLE.
//  q holds last captured value whenever no capture occurs; q never changes without q_valid rising next cycle.
//  Data captured is d[i] sampled at the capture edge (same edge req[i] is sampled).
//  Requests from non-owners during OWN are held off; they must remain asserted to be considered.
//  Widths: hold_cnt is $clog2(MAX_HOLD+1) bits, never exceeds MAX_HOLD; ptr wraps N_REQ-1 -> 0.
//  gnt is always one-hot or zero; busy == |gnt; owner == index of gnt bit.
// STRUCTURE
//  Package ff_arb_pkg: state enum {IDLE, OWN}; function rr_pick(req, ptr) returning {found, idx}.
//  One sub-module: ff_rr_picker (combinational round-robin priority picker, N_REQ param).
//  Top holds FSM, ptr, hold_cnt, gnt/owner regs, and shared q/q_valid register.
// TESTING (N_REQ=4, DATA_W=8, MAX_HOLD=4)
//  Reset: rst=1 2 clks with req=4'b1111 -> gnt=0, busy=0, q=8'h00, q_valid=0 throughout.
//  Single: req=4'b0001, d[0]=8'hA5 at cycle 0 -> gnt=4'b0001 cycle 1; q=8'hA5, q_valid=1 cycle 2.
//  Forced RR: req=4'b0101 held, d[0]=8'h11, d[2]=8'h22 -> gnt 0001 4 captures, then 0100 4 captures,
//   then 0001; no gnt=0 cycle between; q alternates 11/22 in runs of 4.
//  Voluntary: owner 1 drops req after 2 captures (d[1]=8'h3C) -> next edge gnt=0, q_valid=0, q stays 8'h3C.
//  Wrap: owner 3 released with req=4'b1001 -> next gnt=4'b0001 (ptr wrapped to 0).
//  Reset mid-grant: rst=1 while gnt=4'b0100, hold_cnt=2 -> next edge all outputs reset, ptr=0;
//   after rst drops with req=4'b0110 -> gnt=4'b0010.

Source files
------------

// File: rtl/ff_arb_pkg.sv
// Shared types and the round-robin search helper for the shared-register arbiter.
// rr_pick works on a fixed 32-bit request vector so every instance can reuse it.
package ff_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int MAX_REQ = 32;
    localparam int PICK_W  = 5;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First set bit of req[n-1:0], scanning ptr, ptr+1, ... and wrapping at n.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PICK_W-1:0]  ptr,
        input int                 n
    );
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!res.found && req[j]) begin
                    res.found = 1'b1;
                    res.idx   = PICK_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ff_rr_picker.sv
// Combinational round-robin priority picker: lowest index at or after base
// (wrapping) whose request bit is set.
module ff_rr_picker
    import ff_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] base,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;

    always_comb begin
        req_ext              = '0;
        req_ext[N_REQ-1:0]   = req;
        pick                 = rr_pick(req_ext, PICK_W'(base), N_REQ);
        // The range guard is always true for a legal pick; it keeps the full
        // index in use so narrowing it below never drops a meaningful bit.
        found                = pick.found && (pick.idx < PICK_W'(N_REQ));
        idx                  = pick.idx[IDX_W-1:0];
    end

endmodule

// File: rtl/ff_share_arbiter.sv
// Round-robin sequencer sharing one DATA_W-bit register among N_REQ requesters,
// with a per-grant hold limit so no requester can starve the others.
module ff_share_arbiter
    import ff_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  d,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [DATA_W-1:0]        q,
    output logic                     q_valid
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  owner_nxt, owner_inc, pick_base, pick_idx;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
    logic [N_REQ-1:0]  gnt_nxt;
    logic              pick_found, capture, release_now;
    logic [DATA_W-1:0] d_sel;

    assign owner_inc = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    // On release the search restarts just past the owner; from IDLE it uses ptr.
    assign pick_base = (state == OWN) ? owner_inc : ptr;

    ff_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req   (req),
        .base  (pick_base),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign capture     = (state == OWN) && req[owner];
    assign hold_inc    = hold_cnt + 1'b1;
    assign release_now = (state == OWN) && (!req[owner] || hold_inc == HOLD_W'(MAX_HOLD));
    assign d_sel       = d[int'(owner)*DATA_W +: DATA_W];
    assign busy        = |gnt;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        hold_nxt  = hold_cnt;
        gnt_nxt   = gnt;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt         = OWN;
                    owner_nxt         = pick_idx;
                    hold_nxt          = '0;
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                end
            end
            OWN: begin
                if (capture) hold_nxt = hold_inc;
                if (release_now) begin
                    ptr_nxt  = owner_inc;
                    hold_nxt = '0;
                    gnt_nxt  = '0;
                    if (pick_found) begin
                        owner_nxt         = pick_idx;
                        gnt_nxt[pick_idx] = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            q        <= '0;
            q_valid  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            q_valid  <= capture;
            if (capture) q <= d_sel;
        end
    end

endmodule

// File: tb/tb_ff_share_arbiter.sv
// Scenario bench for ff_share_arbiter: each test pushes the expected outputs for
// every edge into a scoreboard queue, and tick() pops and compares after the edge.
module tb_ff_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] d;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic        q_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic       qv;
        string      tag;
    } exp_t;

    exp_t sb[$];

    ff_share_arbiter #(
        .N_REQ    (4),
        .DATA_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_d(input int i, input logic [7:0] v);
        d[i*8 +: 8] = v;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [7:0] qq, input logic qv);
        exp_t e;
        e.gnt = g;
        e.q   = qq;
        e.qv  = qv;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare DUT outputs against the oldest expectation.
    task automatic tick();
        exp_t       e;
        logic [1:0] own_e;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: no expected entry at time %0t", $time);
        end else begin
            e = sb.pop_front();
            if (gnt !== e.gnt) begin
                errors++;
                $display("FAIL %s gnt: got %b want %b", e.tag, gnt, e.gnt);
            end
            checks++;
            if (busy !== (|e.gnt)) begin
                errors++;
                $display("FAIL %s busy: got %b want %b", e.tag, busy, |e.gnt);
            end
            checks++;
            if (q !== e.q) begin
                errors++;
                $display("FAIL %s q: got %h want %h", e.tag, q, e.q);
            end
            checks++;
            if (q_valid !== e.qv) begin
                errors++;
                $display("FAIL %s q_valid: got %b want %b", e.tag, q_valid, e.qv);
            end
            if (|e.gnt) begin
                own_e = 2'd0;
                for (int i = 0; i < 4; i++) if (e.gnt[i]) own_e = 2'(i);
                checks++;
                if (owner !== own_e) begin
                    errors++;
                    $display("FAIL %s owner: got %0d want %0d", e.tag, owner, own_e);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        d   = '0;
        expect_out("do_reset", 4'b0000, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        d   = 32'hFFFF_FFFF;
        expect_out("reset_c1", 4'b0000, 8'h00, 1'b0);
        tick();
        expect_out("reset_c2", 4'b0000, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        set_d(0, 8'hA5);
        expect_out("single_grant", 4'b0001, 8'h00, 1'b0);
        tick();
        expect_out("single_capture", 4'b0001, 8'hA5, 1'b1);
        tick();
        req = 4'b0000;
        expect_out("single_release", 4'b0000, 8'hA5, 1'b0);
        tick();
    endtask

    task automatic test_forced_rr();
        logic [3:0] g, gn;
        logic [7:0] v;
        do_reset();
        req = 4'b0101;
        set_d(0, 8'h11);
        set_d(2, 8'h22);
        expect_out("rr_first_grant", 4'b0001, 8'h00, 1'b0);
        tick();
        for (int r = 0; r < 3; r++) begin
            g  = (r % 2 == 0) ? 4'b0001 : 4'b0100;
            gn = (r % 2 == 0) ? 4'b0100 : 4'b0001;
            v  = (r % 2 == 0) ? 8'h11 : 8'h22;
            for (int k = 0; k < 3; k++) begin
                expect_out("rr_hold", g, v, 1'b1);
                tick();
            end
            expect_out("rr_handover", gn, v, 1'b1);
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_voluntary();
        do_reset();
        req = 4'b0010;
        set_d(1, 8'h3C);
        expect_out("vol_grant", 4'b0010, 8'h00, 1'b0);
        tick();
        expect_out("vol_cap1", 4'b0010, 8'h3C, 1'b1);
        tick();
        expect_out("vol_cap2", 4'b0010, 8'h3C, 1'b1);
        tick();
        req = 4'b0000;
        set_d(1, 8'hFF);
        expect_out("vol_release", 4'b0000, 8'h3C, 1'b0);
        tick();
        expect_out("vol_idle", 4'b0000, 8'h3C, 1'b0);
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b1000;
        set_d(3, 8'h77);
        set_d(0, 8'h99);
        expect_out("wrap_grant3", 4'b1000, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            expect_out("wrap_hold3", 4'b1000, 8'h77, 1'b1);
            tick();
        end
        req = 4'b1001;
        expect_out("wrap_to0", 4'b0001, 8'h77, 1'b1);
        tick();
        expect_out("wrap_cap0", 4'b0001, 8'h99, 1'b1);
        tick();
        req = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        do_reset();
        req = 4'b0001;
        set_d(0, 8'h40);
        expect_out("b2b_grant", 4'b0001, 8'h00, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            v = 8'h50 + 8'(k);
            set_d(0, v);
            expect_out("b2b_regrant", 4'b0001, v, 1'b1);
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001;
        set_d(0, 8'h01);
        set_d(2, 8'h5A);
        expect_out("mid_grant0", 4'b0001, 8'h00, 1'b0);
        tick();
        req = 4'b0100;
        expect_out("mid_switch2", 4'b0100, 8'h00, 1'b0);
        tick();
        expect_out("mid_cap1", 4'b0100, 8'h5A, 1'b1);
        tick();
        expect_out("mid_cap2", 4'b0100, 8'h5A, 1'b1);
        tick();
        rst = 1'b1;
        expect_out("mid_reset", 4'b0000, 8'h00, 1'b0);
        tick();
        rst = 1'b0;
        req = 4'b0110;
        set_d(1, 8'hC3);
        expect_out("mid_after_grant", 4'b0010, 8'h00, 1'b0);
        tick();
        expect_out("mid_after_cap", 4'b0010, 8'hC3, 1'b1);
        tick();
        req = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        d   = '0;
        test_reset();
        test_single();
        test_forced_rr();
        test_voluntary();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d entries remain, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
